// File: rtl/shift_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_serializer_pkg
//  Purpose  : Shared state encoding and default sizing for shift_serializer.
//  Revision : 1.0  initial release
// ============================================================================
package shift_serializer_pkg;

   localparam int c_DEFAULT_SIZE    = 8;
   localparam int c_DEFAULT_DIVIDER = 4;

   localparam logic [1:0] c_IDLE  = 2'b00;
   localparam logic [1:0] c_SHIFT = 2'b01;
   localparam logic [1:0] c_DONE  = 2'b10;

endpackage : shift_serializer_pkg
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bit_tick_gen
//  Purpose  : Bit-period prescaler; oTick marks the last cycle of each period.
//  Revision : 1.0  initial release
// ============================================================================
module bit_tick_gen #(
   parameter int DIVIDER = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Enable,
   output logic oTick
);

   localparam int              c_PW   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [c_PW-1:0] c_TERM = c_PW'(DIVIDER - 1);

   logic [c_PW-1:0] r_count;
   logic            w_term;

   assign w_term = (r_count == c_TERM);

   // Held at zero while disabled so every frame starts with a full bit period.
   always_ff @(posedge Clock) begin
      if (Reset || !Enable) begin
         r_count <= '0;
      end else if (w_term) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign oTick = Enable && w_term;

endmodule : bit_tick_gen
`default_nettype wire

// File: rtl/shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_serializer
//  Purpose  : Valid/ready parallel-to-serial transmitter, MSB first.
//  Revision : 1.0  initial release
// ============================================================================
module shift_serializer
   import shift_serializer_pkg::*;
#(
   parameter int SIZE    = c_DEFAULT_SIZE,
   parameter int DIVIDER = c_DEFAULT_DIVIDER
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [SIZE-1:0] iData,
   input  logic            iValid,
   output logic            oReady,
   output logic            oSerial,
   output logic            oBusy,
   output logic            oDone
);

   localparam int              c_CW   = $clog2(SIZE);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(SIZE - 1);

   logic [1:0]      r_state;
   logic [SIZE-1:0] r_shift;
   logic [c_CW-1:0] r_bit_cnt;
   logic            w_shifting;
   logic            w_tick;

   assign w_shifting = (r_state == c_SHIFT);

   bit_tick_gen #(
      .DIVIDER (DIVIDER)
   ) u_tick (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (w_shifting),
      .oTick  (w_tick)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state   <= c_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (iValid) begin
                  r_state   <= c_SHIFT;
                  r_shift   <= iData;
                  r_bit_cnt <= '0;
               end
            end
            c_SHIFT: begin
               if (w_tick) begin
                  r_shift <= {r_shift[SIZE-2:0], 1'b0};
                  // Counter parks at zero on the final bit so it never reaches SIZE.
                  if (r_bit_cnt == c_LAST) begin
                     r_state   <= c_DONE;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign oReady  = (r_state == c_IDLE);
   assign oBusy   = (r_state == c_SHIFT) || (r_state == c_DONE);
   assign oDone   = (r_state == c_DONE);
   assign oSerial = w_shifting && r_shift[SIZE-1];

endmodule : shift_serializer
`default_nettype wire
